// File: rtl/led_matrix_scan_driver.sv
// Multiplexed 5x7 LED matrix scanner: per-column blank/drive slots, frame-atomic
// image snapshot, and a free-running blink square wave for the column decoders.
module led_matrix_scan_driver #(
    parameter int COL_PERIOD   = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_HALF   = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [34:0] frame_in,
    output logic [4:0]  columns_n,
    output logic [6:0]  rows,
    output logic        frame_start,
    output logic        _1Hz_frequency
);
    localparam int CW = (COL_PERIOD > 1) ? $clog2(COL_PERIOD) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(COL_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   slot_q, slot_d;
    logic [2:0]      col_q, col_d;
    logic [34:0]     snap_q, snap_d;
    logic [4:0]      colsn_q, colsn_d;
    logic [6:0]      rows_q, rows_d;
    logic            fs_q, fs_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            blink_q, blink_d;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        col_d   = col_q;
        snap_d  = snap_q;
        fs_d    = 1'b0;
        case (state_q)
            IDLE: begin
                col_d  = 3'd0;
                slot_d = '0;
                if (enable) begin
                    snap_d  = frame_in;
                    state_d = BLANK;
                    fs_d    = 1'b1;
                end
            end
            BLANK: begin
                slot_d = slot_q + 1'b1;
                if (slot_q == BLANK_LAST) state_d = DRIVE;
            end
            DRIVE: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d  = '0;
                    state_d = BLANK;
                    // Snapshot reloads only at the frame wrap so the image never tears.
                    if (col_q == 3'd4) begin
                        col_d  = 3'd0;
                        snap_d = frame_in;
                        fs_d   = 1'b1;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable && state_q != IDLE) begin
            state_d = IDLE;
            col_d   = 3'd0;
            slot_d  = '0;
            snap_d  = snap_q;
            fs_d    = 1'b0;
        end

        // Outputs are decoded from next state so the registers line up with the FSM.
        colsn_d = 5'b11111;
        rows_d  = 7'd0;
        if (state_d == DRIVE) begin
            case (col_d)
                3'd0: begin colsn_d = 5'b11110; rows_d = snap_d[6:0];   end
                3'd1: begin colsn_d = 5'b11101; rows_d = snap_d[13:7];  end
                3'd2: begin colsn_d = 5'b11011; rows_d = snap_d[20:14]; end
                3'd3: begin colsn_d = 5'b10111; rows_d = snap_d[27:21]; end
                3'd4: begin colsn_d = 5'b01111; rows_d = snap_d[34:28]; end
                default: begin colsn_d = 5'b11111; rows_d = 7'd0; end
            endcase
        end

        bcnt_d  = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 1'b1;
        blink_d = (bcnt_q == BLINK_LAST) ? ~blink_q : blink_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            col_q   <= 3'd0;
            snap_q  <= '0;
            colsn_q <= 5'b11111;
            rows_q  <= 7'd0;
            fs_q    <= 1'b0;
            bcnt_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            col_q   <= col_d;
            snap_q  <= snap_d;
            colsn_q <= colsn_d;
            rows_q  <= rows_d;
            fs_q    <= fs_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
        end
    end

    assign columns_n      = colsn_q;
    assign rows           = rows_q;
    assign frame_start    = fs_q;
    assign _1Hz_frequency = blink_q;
endmodule

// File: doc/led_matrix_scan_driver.md
LED_MATRIX_SCAN_DRIVER -- requirements
Module: led_matrix_scan_driver

Interface
REQ-001 The block SHALL have parameter COL_PERIOD, default 50000, clock cycles per column slot (blank plus drive).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 500, cycles of blanking at the start of each slot; legal range 1 <= BLANK_CYCLES < COL_PERIOD.
REQ-003 The block SHALL have parameter BLINK_HALF, default 25000000, cycles per half-period of the blink output (1 Hz at 50 MHz).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  1 = scan the matrix; 0 = matrix dark.
REQ-007 frame_in  input  35  image from the per-column decoders; column c rows at bits [7c+6:7c], row 0 at the LSB.
REQ-008 columns_n  output  5  one-hot active-low column select; bit c low = column c driven.
REQ-009 rows  output  7  active-high row drive for the selected column.
REQ-010 frame_start  output  1  one-cycle pulse at the start of each frame.
REQ-011 _1Hz_frequency  output  1  square-wave blink source fed back to the column decoders.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 The block SHALL implement FSM states IDLE, BLANK and DRIVE, plus a slot counter, a column index (0-4) and a 35-bit image snapshot.
REQ-014 In IDLE, columns_n SHALL be 5'b11111, rows SHALL be 0, and the column index SHALL be held at 0.
REQ-015 On a clock edge in IDLE with enable=1, the block SHALL take these actions on that edge: snapshot <= frame_in; column <= 0; slot counter <= 0; state <= BLANK; frame_start <= 1.
REQ-016 BLANK SHALL last exactly BLANK_CYCLES cycles, with columns_n=11111 and rows=0, then move to DRIVE.
REQ-017 DRIVE SHALL last exactly COL_PERIOD-BLANK_CYCLES cycles, with columns_n[column]=0 (others 1) and rows=snapshot[7*column+6:7*column].
REQ-018 At the end of DRIVE, the block SHALL return to BLANK with column+1; after column 4 it SHALL wrap to column 0.
REQ-019 On the wrap edge, the block SHALL reload snapshot from frame_in and pulse frame_start for one cycle.
REQ-020 The snapshot SHALL change only at frame boundaries, so frame_in changes mid-frame never tear the displayed image.
REQ-021 Each column slot SHALL be exactly COL_PERIOD cycles, and a frame SHALL be exactly 5*COL_PERIOD cycles.
REQ-022 If enable=0 on any edge in BLANK or DRIVE, the block SHALL go to IDLE on that edge: outputs dark on the next cycle, column=0, no frame_start.
REQ-023 frame_start SHALL be 0 in every cycle other than the one following a snapshot edge.
REQ-024 _1Hz_frequency SHALL toggle every BLINK_HALF cycles, free-running and independent of enable and the FSM.
REQ-025 At no time SHALL more than one bit of columns_n be 0.
REQ-026 Row drive SHALL be nonzero only while a column is selected.
REQ-027 Counters SHALL be sized by $clog2 of their parameter, with no overflow at the maximum legal parameter values.

Reset
REQ-028 While reset=1 at an edge, the block SHALL set state=IDLE, column=0, slot counter=0, blink counter=0 and snapshot=0.
REQ-029 While reset=1 at an edge, outputs SHALL be columns_n=11111, rows=0, frame_start=0 and _1Hz_frequency=0.
REQ-030 Reset SHALL take priority over enable.
REQ-031 Reset asserted mid-frame SHALL produce dark outputs on the following cycle.
REQ-032 After reset releases with enable=1, the first frame_start SHALL occur one cycle after the first edge with reset=0.

Verification (COL_PERIOD=10, BLANK_CYCLES=2, BLINK_HALF=8)
REQ-033 Scenario "first frame": reset 3 cycles, then enable=1 and frame_in=35'h7_FFFF_FFFF -> frame_start high 1 cycle; then 2 dark cycles; then columns_n=11110 with rows=7F for 8 cycles; then 2 dark cycles; then columns_n=11101.
REQ-034 Scenario "walking pattern": frame_in with column c = 7'h01<<c, held for 2 frames -> rows=01,02,04,08,10 in columns 0-4; frame_start period exactly 50 cycles.
REQ-035 Scenario "no tearing": change frame_in to 0 during column 2 DRIVE -> columns 2-4 still show the old data; the new image appears only after the next frame_start.
REQ-036 Scenario "enable drop": deassert enable during column 3 DRIVE -> next cycle columns_n=11111 and rows=0; on re-enable, frame_start fires and scanning restarts at column 0.
REQ-037 Scenario "reset mid-frame and blink": assert reset during column 1 -> next cycle all outputs at reset values; after release, _1Hz_frequency rises after 8 cycles and falls after 16, regardless of enable.
REQ-038 Every scenario SHALL check at every cycle that columns_n is either all-ones or one-hot low, and that rows=0 whenever columns_n=11111.
